memory_tank_ctrl: RTL and testbench



---
 rtl/memory_tank_pkg.sv | 21 ++
 rtl/memory_tank_timing.sv | 32 +++
 rtl/memory_tank_ctrl.sv | 147 ++++++++++++++
 tb/tb_memory_tank_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_tank_pkg.sv
// memory_tank_pkg -- shared constants and FSM state type for the memory tank
// controller.
//   N_DIGITS / N_MINORS : default tank geometry (18 digits x 32 minor cycles)
//   SHORT_W / LONG_W    : short and long word widths in bits
//   state_t             : access FSM states
package memory_tank_pkg;

  localparam int N_DIGITS = 18;  // 17 data digits + 1 gap digit
  localparam int N_MINORS = 32;  // minor cycles per circulation
  localparam int SHORT_W  = 17;
  localparam int LONG_W   = 35;
  localparam int XCNT_W   = 6;   // wide enough to count LONG_W digits

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/memory_tank_timing.sv
// memory_tank_timing -- digit / minor-cycle position generator for the tank.
// Ports:
//   f2_clk    : digit-period clock
//   f2_rst    : synchronous active-high reset (both counters to 0)
//   digit_cnt : current digit, 0..DIGITS_PER_MINOR-1
//   minor_cnt : current minor cycle, 0..MINORS_PER_MAJOR-1
module memory_tank_timing #(
  parameter int DIGITS_PER_MINOR = memory_tank_pkg::N_DIGITS,
  parameter int MINORS_PER_MAJOR = memory_tank_pkg::N_MINORS
) (
  input  logic       f2_clk,
  input  logic       f2_rst,
  output logic [4:0] digit_cnt,
  output logic [4:0] minor_cnt
);

  localparam logic [4:0] D_LAST = 5'(DIGITS_PER_MINOR - 1);
  localparam logic [4:0] M_LAST = 5'(MINORS_PER_MAJOR - 1);

  always_ff @(posedge f2_clk) begin
    if (f2_rst) begin
      digit_cnt <= 5'd0;
      minor_cnt <= 5'd0;
    end else if (digit_cnt == D_LAST) begin
      digit_cnt <= 5'd0;
      minor_cnt <= (minor_cnt == M_LAST) ? 5'd0 : minor_cnt + 5'd1;
    end else begin
      digit_cnt <= digit_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/memory_tank_ctrl.sv
// memory_tank_ctrl -- serial access controller for a recirculating delay-line
// memory tank. A request waits for its minor cycle to come round, then shifts
// 17 (short) or 35 (long) bits into or out of the line, LSB first.
// Optional build macro MEMORY_TANK_MONITOR_EN adds the monitor and
// major_strobe outputs.
// Ports:
//   f2_clk, f2_rst     : digit clock, synchronous active-high reset
//   req/we/long_wd     : request, direction, word size (captured in IDLE)
//   addr, wdata        : short-word address, write data
//   ack, busy, rdata   : completion pulse, busy flag, read result
//   tank_mob, tank_mib : line output bit, line input bit
//   digit_cnt, minor_cnt : current tank position
//   monitor, major_strobe : (MEMORY_TANK_MONITOR_EN only) delayed tank_mob,
//                           last-digit-of-circulation strobe
module memory_tank_ctrl #(
  parameter int DIGITS_PER_MINOR = memory_tank_pkg::N_DIGITS,
  parameter int MINORS_PER_MAJOR = memory_tank_pkg::N_MINORS
) (
`ifdef MEMORY_TANK_MONITOR_EN
  output logic        monitor,
  output logic        major_strobe,
`endif
  input  logic        f2_clk,
  input  logic        f2_rst,
  input  logic        req,
  input  logic        we,
  input  logic        long_wd,
  input  logic [4:0]  addr,
  input  logic [34:0] wdata,
  output logic        ack,
  output logic        busy,
  output logic [34:0] rdata,
  input  logic        tank_mob,
  output logic        tank_mib,
  output logic [4:0]  digit_cnt,
  output logic [4:0]  minor_cnt
);

  import memory_tank_pkg::*;

  state_t              state, state_n;
  logic                we_r, long_r;
  logic [34:0]         wdata_r;
  logic [4:0]          tgt_r;
  logic [XCNT_W-1:0]   xcnt;
  logic [XCNT_W-1:0]   k;
  logic [34:0]         rbuf, rbuf_nxt;
  logic                hit, xfer_first, xfer_on, last;

  memory_tank_timing #(
    .DIGITS_PER_MINOR (DIGITS_PER_MINOR),
    .MINORS_PER_MAJOR (MINORS_PER_MAJOR)
  ) u_timing (
    .f2_clk    (f2_clk),
    .f2_rst    (f2_rst),
    .digit_cnt (digit_cnt),
    .minor_cnt (minor_cnt)
  );

  // Transfer digit 0 must line up with digit 0 of the target minor cycle, so
  // the WAIT cycle that sees the slot arrive is itself the first transfer
  // digit. A long word then runs straight on through the gap digit (bit 17)
  // into the next minor cycle.
  assign hit        = (minor_cnt == tgt_r) && (digit_cnt == 5'd0);
  assign xfer_first = (state == WAIT) && hit;
  assign xfer_on    = xfer_first || (state == XFER);
  assign k          = xfer_first ? '0 : xcnt;
  assign last       = (state == XFER) &&
                      (xcnt == (long_r ? XCNT_W'(LONG_W - 1) : XCNT_W'(SHORT_W - 1)));

  // Recirculate unless writing; reset forces recirculation so an aborted
  // write leaves already-written digits in place and the rest untouched.
  assign tank_mib = (xfer_on && we_r && !f2_rst) ? wdata_r[k] : tank_mob;

  // Read assembly buffer; cleared on the first digit so a short read leaves
  // the upper bits zero.
  always_comb begin
    rbuf_nxt = rbuf;
    if (xfer_first) rbuf_nxt = '0;
    if (xfer_on && !we_r) rbuf_nxt[k] = tank_mob;
  end

  always_comb begin
    state_n = state;
    ack     = 1'b0;
    busy    = 1'b0;
    case (state)
      IDLE: if (req) state_n = WAIT;
      WAIT: begin
        busy = 1'b1;
        if (hit) state_n = XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (f2_rst) begin
      ack  = 1'b0;
      busy = 1'b0;
    end
  end

  always_ff @(posedge f2_clk) begin
    if (f2_rst) begin
      state   <= IDLE;
      we_r    <= 1'b0;
      long_r  <= 1'b0;
      wdata_r <= '0;
      tgt_r   <= '0;
      xcnt    <= '0;
      rbuf    <= '0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        we_r    <= we;
        long_r  <= long_wd;
        wdata_r <= wdata;
        tgt_r   <= long_wd ? {addr[4:1], 1'b0} : addr;
      end
      if (xfer_first)          xcnt <= XCNT_W'(1);
      else if (state == XFER)  xcnt <= xcnt + XCNT_W'(1);
      if (xfer_on && !we_r)    rbuf <= rbuf_nxt;
      // rdata only changes at the end of a read, so it stays valid until
      // the next read completes.
      if (last && !we_r)       rdata <= rbuf_nxt;
    end
  end

`ifdef MEMORY_TANK_MONITOR_EN
  always_ff @(posedge f2_clk) begin
    if (f2_rst) monitor <= 1'b0;
    else        monitor <= tank_mob;
  end

  assign major_strobe = (minor_cnt == 5'(MINORS_PER_MAJOR - 1)) &&
                        (digit_cnt == 5'(DIGITS_PER_MINOR - 1));
`endif

endmodule

// File: tb/tb_memory_tank_ctrl.sv
// tb_memory_tank_ctrl -- directed bench for memory_tank_ctrl. The delay line
// is modelled as a 576-bit circular buffer clocked alongside the DUT; an
// expected image of the tank is maintained independently.
module tb_memory_tank_ctrl;

  localparam int TANK = 576;

  logic        f2_clk = 1'b0;
  logic        f2_rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, long_wd = 1'b0;
  logic [4:0]  addr = '0;
  logic [34:0] wdata = '0;
  logic        ack, busy, tank_mib, tank_mob;
  logic [34:0] rdata;
  logic [4:0]  digit_cnt, minor_cnt;
`ifdef MEMORY_TANK_MONITOR_EN
  logic        monitor, major_strobe;
`endif

  bit line    [TANK];
  bit exp_img [TANK];
  int p = 0;
  bit hold_p = 1'b1;
  bit inited = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 f2_clk = ~f2_clk;

  memory_tank_ctrl dut (
`ifdef MEMORY_TANK_MONITOR_EN
    .monitor      (monitor),
    .major_strobe (major_strobe),
`endif
    .f2_clk    (f2_clk),
    .f2_rst    (f2_rst),
    .req       (req),
    .we        (we),
    .long_wd   (long_wd),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .busy      (busy),
    .rdata     (rdata),
    .tank_mob  (tank_mob),
    .tank_mib  (tank_mib),
    .digit_cnt (digit_cnt),
    .minor_cnt (minor_cnt)
  );

  function automatic bit pat(int i);
    return bit'((i ^ (i >> 1) ^ (i >> 3)) & 1);
  endfunction

  // Delay line: the bit leaving now re-enters as whatever tank_mib carries.
  assign tank_mob = line[p];
  always @(posedge f2_clk) begin
    if (!inited) begin
      for (int i = 0; i < TANK; i++) line[i] <= pat(i);
      inited <= 1'b1;
    end else begin
      line[p] <= tank_mib;
    end
    p <= hold_p ? 0 : (p + 1) % TANK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_img(input string tag);
    int nb = 0;
    for (int i = 0; i < TANK; i++) if (line[i] != exp_img[i]) nb++;
    chk(tag, 64'(nb), 64'd0);
  endtask

  function automatic logic [34:0] img_word(int tgt, int len);
    logic [34:0] w = '0;
    for (int j = 0; j < len; j++) w[j] = exp_img[(tgt * 18 + j) % TANK];
    return w;
  endfunction

  // One access; lat = cycles from the req cycle to the ack cycle.
  task automatic access(input bit w, input bit lw, input logic [4:0] a,
                        input logic [34:0] d, input bit sync,
                        input logic [4:0] sm, input logic [4:0] sd,
                        output int lat);
    int guard, tgt, len;
    @(negedge f2_clk);
    guard = 0;
    while (busy && guard < 2000) begin @(negedge f2_clk); guard++; end
    if (sync) begin
      guard = 0;
      while (!(minor_cnt == sm && digit_cnt == sd) && guard < 700) begin
        @(negedge f2_clk); guard++;
      end
    end
    req = 1'b1; we = w; long_wd = lw; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge f2_clk);
      req = 1'b0;
      lat++;
    end while (!ack && lat < 1300);
    if (!ack) chk("ack_timeout", 64'd0, 64'd1);
    if (w) begin
      tgt = lw ? (int'(a) & ~1) : int'(a);
      len = lw ? 35 : 17;
      for (int j = 0; j < len; j++) exp_img[(tgt * 18 + j) % TANK] = d[j];
    end
  endtask

  initial begin
    int lat, acks, guard;
    logic [34:0] v, r_prev;

    for (int i = 0; i < TANK; i++) exp_img[i] = pat(i);

    repeat (3) @(negedge f2_clk);
    chk("rst_digit", 64'(digit_cnt), 64'd0);
    chk("rst_minor", 64'(minor_cnt), 64'd0);
    chk("rst_ack",   64'(ack),       64'd0);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_rdata", 64'(rdata),     64'd0);
    chk("rst_recirc", 64'(tank_mib), 64'(tank_mob));
    f2_rst = 1'b0;
    hold_p = 1'b0;

    // Counter wrap 17 -> 0 with minor increment.
    repeat (17) @(negedge f2_clk);
    chk("digit_17", 64'(digit_cnt), 64'd17);
    chk("minor_0",  64'(minor_cnt), 64'd0);
    @(negedge f2_clk);
    chk("digit_wrap", 64'(digit_cnt), 64'd0);
    chk("minor_inc",  64'(minor_cnt), 64'd1);

    // Short write / read at addr 5.
    access(1'b1, 1'b0, 5'd5, 35'h1ABCD, 1'b0, 5'd0, 5'd0, lat);
    check_img("img_short_wr");
    access(1'b0, 1'b0, 5'd5, 35'h0, 1'b0, 5'd0, 5'd0, lat);
    chk("rd_short",    64'(rdata), 64'h1ABCD);
    chk("rd_short_hi", 64'(rdata[34:17]), 64'd0);

    // Long write at addr 7 lands in minors 6/7; read back via addr 6.
    access(1'b1, 1'b1, 5'd7, 35'h5_5555_5555, 1'b0, 5'd0, 5'd0, lat);
    check_img("img_long_wr");
    access(1'b0, 1'b1, 5'd6, 35'h0, 1'b0, 5'd0, 5'd0, lat);
    chk("rd_long", 64'(rdata), 64'h5_5555_5555);

    // Req at minor 4 digit 0 for tgt 4: a full circulation of waiting.
    // Counting the req cycle and the ack cycle both, that is 576+17+1
    // cycles, so ack lands 593 cycles after req.
    access(1'b0, 1'b0, 5'd4, 35'h0, 1'b1, 5'd4, 5'd0, lat);
    chk("lat_tgt4", 64'(lat), 64'd593);
    chk("rd_tgt4",  64'(rdata), 64'(img_word(4, 17)));

    // Req at minor 4 digit 17 for tgt 5: transfer starts next cycle,
    // 17 transfer digits then DONE -> ack 18 cycles after req.
    r_prev = rdata;
    access(1'b1, 1'b0, 5'd5, 35'h0F0F0, 1'b1, 5'd4, 5'd17, lat);
    chk("lat_next",    64'(lat), 64'd18);
    chk("rd_keep_wr",  64'(rdata), 64'(r_prev));
    check_img("img_next_wr");

    // Long access at 30 spans minors 30-31; ack at minor 31 digit 17.
    v = 35'h4_3210_FEDC;
    access(1'b1, 1'b1, 5'd30, v, 1'b0, 5'd0, 5'd0, lat);
    access(1'b0, 1'b1, 5'd30, 35'h0, 1'b0, 5'd0, 5'd0, lat);
    chk("rd_wrap", 64'(rdata), 64'(v));
    @(negedge f2_clk);
    chk("wrap_minor", 64'(minor_cnt), 64'd0);
    chk("wrap_digit", 64'(digit_cnt), 64'd0);
    check_img("img_wrap");

    // Requests while busy must be dropped; they are writes so a wrongly
    // accepted one would also show up in the tank image.
    guard = 0;
    while (busy && guard < 2000) begin @(negedge f2_clk); guard++; end
    req = 1'b1; we = 1'b0; long_wd = 1'b0; addr = 5'd3; wdata = '0;
    @(negedge f2_clk);
    acks = 0;
    for (int i = 0; i < 1300; i++) begin
      req = (i == 1 || i == 8 || i == 15);
      we = 1'b1; addr = 5'd3; wdata = 35'h7_FFFF_FFFF;
      @(negedge f2_clk);
      if (ack) acks++;
    end
    req = 1'b0; we = 1'b0;
    chk("busy_one_ack", 64'(acks), 64'd1);
    chk("busy_rd",      64'(rdata), 64'(img_word(3, 17)));
    check_img("img_busy");

    // Reset during digit 10 of a short write to minor 9.
    v = '0;
    for (int j = 0; j < 17; j++) v[j] = ~exp_img[9 * 18 + j];
    @(negedge f2_clk);
    req = 1'b1; we = 1'b1; long_wd = 1'b0; addr = 5'd9; wdata = v;
    @(negedge f2_clk);
    req = 1'b0;
    guard = 0;
    while (!(minor_cnt == 5'd9 && digit_cnt == 5'd10) && guard < 700) begin
      @(negedge f2_clk); guard++;
    end
    chk("mid_busy", 64'(busy), 64'd1);
    f2_rst = 1'b1;
    #1;
    chk("mid_recirc", 64'(tank_mib), 64'(tank_mob));
    chk("mid_ack",    64'(ack), 64'd0);
    @(negedge f2_clk);
    f2_rst = 1'b0;
    chk("mid_post_busy",  64'(busy), 64'd0);
    chk("mid_post_digit", 64'(digit_cnt), 64'd0);
    acks = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge f2_clk);
      if (ack) acks++;
    end
    chk("mid_no_ack", 64'(acks), 64'd0);
    for (int j = 0; j < 10; j++) exp_img[9 * 18 + j] = v[j];
    check_img("img_mid_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
